// File: rtl/hex_display_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex_display_scanner: time-multiplexed common-anode 7-segment hex driver  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hex_display_scanner #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lzb,
  input  logic                  load,
  output logic [0:6]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   mask_q;
  logic                lzb_q;
  logic [DW-1:0]       div_cnt;
  logic [IW-1:0]       idx;
  logic [BW-1:0]       blk_cnt;
  logic                phase;

  logic                tick;
  logic                frame_end;
  logic [3:0]          cur_digit;
  logic                lz_blank;
  logic                higher_nz;
  logic                blanked;

  function automatic logic [0:6] decode(input logic [3:0] v);
    logic [0:6] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign tick      = (div_cnt == DIV_LAST);
  assign frame_end = tick && (idx == IDX_LAST);
  assign cur_digit = data_q[{idx, 2'b00} +: 4];

  // Scan from the top digit down; a digit is a leading zero when it and all above it are zero.
  always_comb begin
    lz_blank  = 1'b0;
    higher_nz = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      higher_nz = higher_nz | (data_q[4*i +: 4] != 4'h0);
      if (idx == IW'(i)) begin
        lz_blank = lzb_q & ~higher_nz;
      end
    end
  end

  assign blanked = lz_blank | (mask_q[idx] & phase);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      dp_q    <= '0;
      mask_q  <= '0;
      lzb_q   <= 1'b0;
      div_cnt <= '0;
      idx     <= '0;
      blk_cnt <= '0;
      phase   <= 1'b0;
      seg     <= 7'b1111111;
      dp_n    <= 1'b1;
      an_n    <= '1;
    end else begin
      if (load) begin
        data_q <= data;
        dp_q   <= dp;
        mask_q <= blink_mask;
        lzb_q  <= lzb;
      end

      if (tick) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (frame_end) begin
        if (blk_cnt == BLK_LAST) begin
          blk_cnt <= '0;
          phase   <= ~phase;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end

      // Outputs reflect the state held before this edge, giving one cycle of latency.
      if (blanked) begin
        seg  <= 7'b1111111;
        dp_n <= 1'b1;
        an_n <= '1;
      end else begin
        seg  <= decode(cur_digit);
        dp_n <= ~dp_q[idx];
        an_n <= ~(DIGITS'(1) << idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hex_display_scanner: scoreboard bench for hex_display_scanner         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blink_mask = '0;
  logic        lzb = 1'b0;
  logic        load = 1'b0;
  logic [0:6]  seg;
  logic        dp_n;
  logic [3:0]  an_n;

  int cyc;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         k;
    logic [0:6] seg;
    logic [3:0] an;
    logic       dpn;
  } exp_t;

  exp_t sb[$];

  logic [0:6] segt [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  hex_display_scanner #(
    .DIGITS(4),
    .SCAN_DIV(4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data(data),
    .dp(dp),
    .blink_mask(blink_mask),
    .lzb(lzb),
    .load(load),
    .seg(seg),
    .dp_n(dp_n),
    .an_n(an_n)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; output at edge k reflects state after edge k-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // lzmask lists digits that are hand-determined to be leading-zero blanked.
  function automatic exp_t expect_at(input int k, input logic [15:0] d, input logic [3:0] dpv,
                                     input logic [3:0] m, input logic [3:0] lzmask);
    exp_t e;
    int   i;
    logic ph;
    i  = ((k - 1) / 4) % 4;
    ph = (((k - 1) / 32) % 2) == 1;
    e.k = k;
    if (lzmask[i] || (m[i] && ph)) begin
      e.seg = 7'b1111111;
      e.an  = 4'b1111;
      e.dpn = 1'b1;
    end else begin
      e.seg   = segt[d[4*i +: 4]];
      e.an    = 4'b1111;
      e.an[i] = 1'b0;
      e.dpn   = ~dpv[i];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].k < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL missed k=%0d: got no sample, expected one at cycle %0d", sb[0].k, sb[0].k);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].k == cyc) begin
        e = sb.pop_front();
        check($sformatf("seg k=%0d", e.k), 32'(seg), 32'(e.seg));
        check($sformatf("an_n k=%0d", e.k), 32'(an_n), 32'(e.an));
        check($sformatf("dp_n k=%0d", e.k), 32'(dp_n), 32'(e.dpn));
      end
    end
  end

  task automatic apply(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] m,
                       input logic lz, input logic [3:0] lzmask, input int win, input bit align);
    int l;
    @(posedge clk); #1;
    if (align) begin
      for (int t = 0; t < 32 && (cyc % 16) != 7; t++) begin
        @(posedge clk); #1;
      end
    end
    data = d; dp = dpv; blink_mask = m; lzb = lz; load = 1'b1;
    @(posedge clk); #1;
    l = cyc;
    load = 1'b0;
    // Garbage on the inputs while load is low must be ignored.
    data = ~d; dp = ~dpv; blink_mask = ~m; lzb = ~lz;
    for (int j = 1; j <= win; j++) sb.push_back(expect_at(l + j, d, dpv, m, lzmask));
    repeat (win + 1) @(posedge clk);
    #1;
  endtask

  task automatic check_blank(input string tag);
    check({tag, " seg"}, 32'(seg), 32'(7'b1111111));
    check({tag, " an_n"}, 32'(an_n), 32'(4'b1111));
    check({tag, " dp_n"}, 32'(dp_n), 32'(1'b1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_blank("in reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 4; j++) sb.push_back(expect_at(j, 16'h0, 4'h0, 4'h0, 4'h0));
    repeat (5) @(posedge clk);

    apply(16'h3A5F, 4'h0, 4'h0, 1'b0, 4'b0000, 20, 1'b0);
    apply(16'h0123, 4'h0, 4'h0, 1'b0, 4'b0000, 20, 1'b0);
    apply(16'hBCDE, 4'h0, 4'h0, 1'b0, 4'b0000, 20, 1'b0);
    apply(16'h9864, 4'h0, 4'h0, 1'b0, 4'b0000, 20, 1'b0);
    apply(16'h0070, 4'h0, 4'h0, 1'b1, 4'b1100, 20, 1'b0);
    apply(16'h0000, 4'h0, 4'h0, 1'b1, 4'b1110, 20, 1'b0);
    apply(16'h1234, 4'b0010, 4'b0001, 1'b0, 4'b0000, 80, 1'b0);
    apply(16'hC0DE, 4'h0, 4'h0, 1'b0, 4'b0000, 20, 1'b1);

    // Async reset while digit 2 is on screen, between clock edges.
    for (int t = 0; t < 32 && (cyc % 16) != 9; t++) begin
      @(posedge clk); #1;
    end
    check("pre-reset an_n", 32'(an_n), 32'(4'b1011));
    #2;
    rst_n = 1'b0;
    #1;
    check_blank("async reset");
    @(posedge clk); #1;
    check_blank("reset held");
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 8; j++) sb.push_back(expect_at(j, 16'h0, 4'h0, 4'h0, 4'h0));
    repeat (10) @(posedge clk);
    apply(16'h5555, 4'h0, 4'hF, 1'b0, 4'b0000, 48, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
